// File: rtl/gshare_predictor_if.sv
// Request / prediction / resolve bus for the gshare branch predictor.
//   req_valid, req_addr  : prediction request from the front end
//   req_ready            : predictor accepts requests (low while initialising)
//   pred_valid/taken/idx : prediction result, one cycle after acceptance
//   res_valid/idx/taken/pred : branch outcome used to train the table
// master = front end (requester/resolver), slave = predictor.
interface gshare_predictor_if #(
    parameter int unsigned ADDR_W = 10
) ();
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              pred_valid;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_idx;
    logic              res_valid;
    logic [ADDR_W-1:0] res_idx;
    logic              res_taken;
    logic              res_pred;

    modport master (
        output req_valid, req_addr, res_valid, res_idx, res_taken, res_pred,
        input  req_ready, pred_valid, pred_taken, pred_idx
    );

    modport slave (
        input  req_valid, req_addr, res_valid, res_idx, res_taken, res_pred,
        output req_ready, pred_valid, pred_taken, pred_idx
    );
endinterface

// File: rtl/gshare_predictor.sv
// Gshare / bimodal branch direction predictor.
// A table of 2**ADDR_W saturating counters is swept to INIT_CTR after reset,
// then serves one prediction per cycle and trains on resolved outcomes.
// Ports:
//   clk, rst_b     : clock, asynchronous active-high reset
//   mode           : 0 = bimodal index (addr), 1 = gshare index (addr ^ GHR)
//   bus            : request / prediction / resolve interface (slave side)
//   mispredict_cnt : saturating count of resolves where res_pred != res_taken
//   init_done      : table sweep complete, predictor running
module gshare_predictor #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned HIST_W   = 8,
    parameter int unsigned CTR_W    = 2,
    parameter int unsigned INIT_CTR = 2**(CTR_W-1)
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic                mode,
    gshare_predictor_if.slave   bus,
    output logic [15:0]         mispredict_cnt,
    output logic                init_done
);

    localparam int unsigned DEPTH = 2**ADDR_W;
    // Keep a 1-bit register when history is disabled; it is masked out of the index.
    localparam int unsigned GHR_W = (HIST_W == 0) ? 1 : HIST_W;
    localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_MIN = '0;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                ready_q;
    logic                done_q;
    logic [GHR_W-1:0]    ghr_q;
    logic [15:0]         mis_cnt_q;
    logic                pred_valid_q;
    logic                pred_taken_q;
    logic [ADDR_W-1:0]   pred_idx_q;

    logic [CTR_W-1:0]    ctr_tbl [DEPTH];

    logic                accept_c;
    logic                resolve_c;
    logic [ADDR_W-1:0]   hist_ext_c;
    logic [ADDR_W-1:0]   idx_c;
    logic [CTR_W-1:0]    ctr_cur_c;
    logic [CTR_W-1:0]    ctr_upd_c;
    logic [GHR_W-1:0]    ghr_next_c;

    // Next-state logic: sweep the table once, then run until reset.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_INIT: begin
                ptr_d = ptr_q + ADDR_W'(1);
                if (ptr_q == {ADDR_W{1'b1}}) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    // ready_q mirrors the RUN state, so requests/resolves are ignored during the sweep.
    assign accept_c  = bus.req_valid && ready_q;
    assign resolve_c = bus.res_valid && ready_q;

    // Index selection; history is zero-extended into the address width.
    assign hist_ext_c = (HIST_W == 0) ? '0 : ADDR_W'(ghr_q);
    assign idx_c      = mode ? (bus.req_addr ^ hist_ext_c) : bus.req_addr;

    // Saturating counter update for the resolved entry.
    assign ctr_cur_c = ctr_tbl[bus.res_idx];
    always_comb begin
        ctr_upd_c = ctr_cur_c;
        if (bus.res_taken) begin
            if (ctr_cur_c != CTR_MAX) ctr_upd_c = ctr_cur_c + CTR_W'(1);
        end else begin
            if (ctr_cur_c != CTR_MIN) ctr_upd_c = ctr_cur_c - CTR_W'(1);
        end
    end

    // Shift the outcome in at the LSB; truncation drops the oldest bit.
    assign ghr_next_c = GHR_W'({ghr_q, bus.res_taken});

    // Counter table: sweep writes during INIT, training writes in RUN.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            ctr_tbl[ptr_q] <= CTR_W'(INIT_CTR);
        end else if (resolve_c) begin
            ctr_tbl[bus.res_idx] <= ctr_upd_c;
        end
    end

    // Control, history, statistics and prediction registers.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state_q      <= ST_INIT;
            ptr_q        <= '0;
            ready_q      <= 1'b0;
            done_q       <= 1'b0;
            ghr_q        <= '0;
            mis_cnt_q    <= '0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_idx_q   <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            ready_q      <= (state_d == ST_RUN);
            done_q       <= (state_d == ST_RUN);
            pred_valid_q <= accept_c;
            // Read happens before this edge's training write: same-cycle
            // resolve to the same entry is seen by the next request only.
            if (accept_c) begin
                pred_taken_q <= ctr_tbl[idx_c][CTR_W-1];
                pred_idx_q   <= idx_c;
            end
            if (resolve_c) begin
                ghr_q <= ghr_next_c;
                if ((bus.res_pred != bus.res_taken) && (mis_cnt_q != 16'hFFFF)) begin
                    mis_cnt_q <= mis_cnt_q + 16'd1;
                end
            end
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.pred_valid = pred_valid_q;
    assign bus.pred_taken = pred_taken_q;
    assign bus.pred_idx   = pred_idx_q;
    assign mispredict_cnt = mis_cnt_q;
    assign init_done      = done_q;

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor (default parameters).
module tb_gshare_predictor;
    localparam int unsigned AW = 10;

    logic        clk = 1'b0;
    logic        rst_b = 1'b1;
    logic        mode = 1'b0;
    logic [15:0] mispredict_cnt;
    logic        init_done;

    gshare_predictor_if #(.ADDR_W(AW)) bus ();

    gshare_predictor #(
        .ADDR_W(AW),
        .HIST_W(8),
        .CTR_W (2)
    ) dut (
        .clk           (clk),
        .rst_b         (rst_b),
        .mode          (mode),
        .bus           (bus),
        .mispredict_cnt(mispredict_cnt),
        .init_done     (init_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          req;
        logic          md;
        logic [AW-1:0] addr;
        logic          res;
        logic [AW-1:0] ridx;
        logic          rt;
        logic          rp;
        logic          et;
        logic [AW-1:0] eidx;
    } vec_t;

    typedef struct packed {
        logic          t;
        logic [AW-1:0] idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];
    int   n_test = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_test++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit req, input bit md, input int addr, input bit res,
                                input int ridx, input bit rt, input bit rp,
                                input bit et, input int eidx);
        vec_t v;
        v.req  = req;  v.md = md;  v.addr = AW'(addr);
        v.res  = res;  v.ridx = AW'(ridx);  v.rt = rt;  v.rp = rp;
        v.et   = et;   v.eidx = AW'(eidx);
        return v;
    endfunction

    task automatic set_in(input bit req, input bit md, input logic [AW-1:0] addr, input bit res,
                          input logic [AW-1:0] ridx, input bit rt, input bit rp);
        bus.req_valid = req;
        mode          = md;
        bus.req_addr  = addr;
        bus.res_valid = res;
        bus.res_idx   = ridx;
        bus.res_taken = rt;
        bus.res_pred  = rp;
    endtask

    task automatic idle();
        set_in(1'b0, mode, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req_ready"},  32'(bus.req_ready), 32'd0);
        check({tag, "_init_done"},  32'(init_done), 32'd0);
        check({tag, "_pred_valid"}, 32'(bus.pred_valid), 32'd0);
        check({tag, "_pred_taken"}, 32'(bus.pred_taken), 32'd0);
        check({tag, "_pred_idx"},   32'(bus.pred_idx), 32'd0);
        check({tag, "_mis_cnt"},    32'(mispredict_cnt), 32'd0);
    endtask

    // Counts edges from reset release until req_ready rises (bounded).
    task automatic wait_init(input string tag);
        int n = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            n++;
            if (n == 1023) check({tag, "_done_low"}, 32'(init_done), 32'd0);
            if (bus.req_ready) break;
        end
        check({tag, "_cycles"}, 32'(n), 32'd1024);
        check({tag, "_init_done"}, 32'(init_done), 32'd1);
    endtask

    task automatic push_if_req(input vec_t v);
        exp_t e;
        if (v.req) begin
            e.t   = v.et;
            e.idx = v.eidx;
            sbq.push_back(e);
        end
    endtask

    // Scoreboard: every prediction must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.pred_valid) begin
            if (sbq.size() == 0) begin
                n_test++;
                n_fail++;
                $display("FAIL unexpected_pred: got pred_idx 0x%0h expected no prediction", bus.pred_idx);
            end else begin
                e = sbq.pop_front();
                check("pred_taken", 32'(bus.pred_taken), 32'(e.t));
                check("pred_idx",   32'(bus.pred_idx),   32'(e.idx));
            end
        end
    end

    initial begin
        // req md addr   res ridx   rt rp  exp_t exp_idx
        vecs.push_back(mk(1, 0, 'h123, 0, 0,     0, 0, 1, 'h123)); // untouched entry: weakly taken
        vecs.push_back(mk(1, 1, 'h0FF, 0, 0,     0, 0, 1, 'h0FF)); // GHR still 0 after init
        vecs.push_back(mk(0, 0, 0,     1, 'h005, 0, 1, 0, 0));     // idx5: 2->1, mispredict
        vecs.push_back(mk(0, 0, 0,     1, 'h005, 0, 1, 0, 0));     // 1->0
        vecs.push_back(mk(0, 0, 0,     1, 'h005, 0, 1, 0, 0));     // stays 0
        vecs.push_back(mk(1, 0, 'h005, 0, 0,     0, 0, 0, 'h005));
        vecs.push_back(mk(0, 0, 0,     1, 'h005, 0, 0, 0, 0));     // floor saturation
        vecs.push_back(mk(1, 0, 'h005, 0, 0,     0, 0, 0, 'h005));
        vecs.push_back(mk(0, 0, 0,     1, 'h007, 0, 0, 0, 0));     // idx7 -> 01
        vecs.push_back(mk(1, 0, 'h007, 1, 'h007, 1, 0, 0, 'h007)); // same-cycle: pre-update 01
        vecs.push_back(mk(1, 0, 'h007, 0, 0,     0, 0, 1, 'h007)); // now 10
        vecs.push_back(mk(0, 0, 0,     1, 'h200, 1, 1, 0, 0));     // build GHR = A5
        vecs.push_back(mk(0, 0, 0,     1, 'h200, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,     1, 'h200, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,     1, 'h200, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,     1, 'h200, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,     1, 'h200, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,     1, 'h200, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,     1, 'h200, 1, 1, 0, 0));
        vecs.push_back(mk(1, 1, 'h3C0, 0, 0,     0, 0, 1, 'h365)); // 3C0 ^ A5
        vecs.push_back(mk(1, 0, 'h3C0, 0, 0,     0, 0, 1, 'h3C0)); // mode switch
        vecs.push_back(mk(1, 1, 'h0A0, 0, 0,     0, 0, 0, 'h005)); // gshare hits trained idx5
        vecs.push_back(mk(1, 1, 'h3C0, 0, 0,     0, 0, 1, 'h365)); // GHR unchanged by predictions
        vecs.push_back(mk(0, 0, 0,     1, 'h007, 1, 1, 0, 0));     // idx7 2->3
        vecs.push_back(mk(0, 0, 0,     1, 'h007, 1, 1, 0, 0));     // ceiling saturation
        vecs.push_back(mk(0, 0, 0,     1, 'h007, 0, 0, 0, 0));     // 3->2
        vecs.push_back(mk(0, 0, 0,     1, 'h007, 0, 0, 0, 0));     // 2->1
        vecs.push_back(mk(1, 0, 'h007, 0, 0,     0, 0, 0, 'h007));

        // Reset state, then a sweep with requests and mispredicting resolves asserted.
        idle();
        repeat (3) @(posedge clk);
        #1;
        check_reset("rst0");
        rst_b = 1'b0;
        set_in(1'b1, 1'b1, AW'('h005), 1'b1, AW'('h005), 1'b1, 1'b0);
        wait_init("init0");
        idle();
        check("mis_cnt_after_init", 32'(mispredict_cnt), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            set_in(vecs[i].req, vecs[i].md, vecs[i].addr, vecs[i].res,
                   vecs[i].ridx, vecs[i].rt, vecs[i].rp);
            push_if_req(vecs[i]);
            @(posedge clk); #1;
        end
        idle();
        @(posedge clk); #1;
        check("hold_pred_valid", 32'(bus.pred_valid), 32'd0);
        check("hold_pred_idx",   32'(bus.pred_idx),   32'h007);
        check("hold_pred_taken", 32'(bus.pred_taken), 32'd0);
        check("sbq_drained_1",   32'(sbq.size()),     32'd0);
        check("mis_cnt_vec",     32'(mispredict_cnt), 32'd4);

        // Mispredict counter saturation.
        set_in(1'b0, 1'b0, '0, 1'b1, AW'('h100), 1'b0, 1'b1);
        repeat (65540) @(posedge clk);
        #1;
        idle();
        check("mis_cnt_sat", 32'(mispredict_cnt), 32'hFFFF);

        // Reset in RUN, then reset again at sweep pointer 300.
        rst_b = 1'b1;
        @(posedge clk); #1;
        check_reset("rst_run");
        rst_b = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        check("mid_sweep_ready", 32'(bus.req_ready), 32'd0);
        rst_b = 1'b1;
        @(posedge clk); #1;
        check_reset("rst_sweep");
        rst_b = 1'b0;
        wait_init("init_restart");

        // Table and GHR re-initialised: trained idx5 is weakly taken again, GHR is 0.
        begin
            vec_t v;
            v = mk(1, 0, 'h005, 0, 0, 0, 0, 1, 'h005);
            set_in(v.req, v.md, v.addr, v.res, v.ridx, v.rt, v.rp);
            push_if_req(v);
            @(posedge clk); #1;
            v = mk(1, 1, 'h0A0, 0, 0, 0, 0, 1, 'h0A0);
            set_in(v.req, v.md, v.addr, v.res, v.ridx, v.rt, v.rp);
            push_if_req(v);
            @(posedge clk); #1;
        end
        idle();
        @(posedge clk); #1;
        check("sbq_drained_2", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
        $finish;
    end
endmodule

// File: doc/gshare_predictor.md
GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning branch address width and log2 of the table depth.
REQ-002 SHALL have parameter HIST_W, default 8, meaning global history register width, legal range 0..ADDR_W.
REQ-003 SHALL have parameter CTR_W, default 2, meaning saturating counter width, legal range 2..4.
REQ-004 SHALL have parameter INIT_CTR, default 2**(CTR_W-1), meaning the weakly-taken counter value written at init.
REQ-005 SHALL have port clk, input, 1, meaning the clock; all state updates on rising edge.
REQ-006 SHALL have port rst_b, input, 1, meaning asynchronous, active-high reset.
REQ-007 SHALL have port mode, input, 1, meaning index mode: 0 is bimodal (addr), 1 is gshare (addr XOR history).
REQ-008 SHALL have port req_valid, input, 1, meaning a prediction request.
REQ-009 SHALL have port req_addr, input, ADDR_W, meaning the branch address.
REQ-010 SHALL have port req_ready, output, 1, meaning requests are accepted; low during init.
REQ-011 SHALL have port pred_valid, output, 1, meaning pred_taken/pred_idx are valid this cycle.
REQ-012 SHALL have port pred_taken, output, 1, meaning the predicted direction.
REQ-013 SHALL have port pred_idx, output, ADDR_W, meaning the table index used; it is returned on resolve.
REQ-014 SHALL have port res_valid, input, 1, meaning a branch outcome.
REQ-015 SHALL have port res_idx, input, ADDR_W, meaning the index to update (an earlier pred_idx).
REQ-016 SHALL have port res_taken, input, 1, meaning the actual outcome.
REQ-017 SHALL have port res_pred, input, 1, meaning the direction originally predicted.
REQ-018 SHALL have port mispredict_cnt, output, 16, meaning the saturating mispredict count.
REQ-019 SHALL have port init_done, output, 1, meaning the table sweep is complete.

Function
REQ-020 SHALL hold a table of 2**ADDR_W counters, each CTR_W bits wide, plus a HIST_W-bit GHR.
REQ-021 SHALL run the FSM states INIT -> RUN; reset enters INIT with sweep pointer 0.
REQ-022 In INIT: write INIT_CTR to entry[ptr], increment ptr once per cycle, and after the entry 2**ADDR_W-1 write go to RUN.
REQ-023 SHALL assert init_done and req_ready only in RUN; init lasts exactly 2**ADDR_W cycles after reset release.
REQ-024 SHALL ignore requests and resolves in INIT, with no table, GHR or counter change.
REQ-025 Request is accepted when req_valid && req_ready; idx = mode ? req_addr ^ {zero-ext GHR} : req_addr.
REQ-026 SHALL give pred_valid, pred_taken = counter MSB, and pred_idx exactly 1 cycle after acceptance; otherwise pred_valid=0 and the other outputs hold.
REQ-027 On resolve: counter at res_idx +1 if res_taken, saturating at 2**CTR_W-1; -1 if not taken, saturating at 0.
REQ-028 On resolve: GHR <= {GHR[HIST_W-2:0], res_taken}; when HIST_W=0 there is no GHR and gshare equals bimodal.
REQ-029 GHR changes only on resolve, never at prediction.
REQ-030 Same-cycle request and resolve, including the same index: the request SHALL use the pre-update counter and pre-shift GHR.
REQ-031 On resolve with res_pred != res_taken: mispredict_cnt +1, saturating at 16'hFFFF.
REQ-032 A mode change SHALL take effect on the next accepted request without clearing the table.

Reset
REQ-033 While rst_b is asserted: state=INIT, ptr=0, GHR=0, mispredict_cnt=0, pred_valid=0, pred_taken=0, pred_idx=0, req_ready=0, init_done=0.
REQ-034 Reset asserted mid-sweep or mid-RUN SHALL abort the current operation and restart the full INIT sweep after release.

Verification
REQ-035 Reset release with defaults -> req_ready=0 for 1024 cycles, then 1; the first request to any address gives pred_taken=1.
REQ-036 Bimodal, addr 0x005, three not-taken resolves at idx 5 -> counter 0, the next prediction is 0, and a further not-taken resolve keeps it at 0.
REQ-037 Gshare, GHR=8'hA5, req_addr 0x3C0 -> pred_idx 0x365 one cycle later.
REQ-038 Same-cycle request and taken resolve at idx 7 with counter 01 -> pred_taken=0, then the counter becomes 10.
REQ-039 Resolves with res_pred != res_taken, 65540 times -> mispredict_cnt=16'hFFFF, with no wrap.
REQ-040 Reset asserted at sweep ptr 300 -> after release the sweep restarts at 0 and init_done rises after 1024 cycles.
